ifu_fetch: RTL
==============

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch stage; the responding end of the pipeline controller's redirect protocol.
//  Consumes jup_o/jup_addr_r, issues word fetches to instruction memory and returns instructions with ivalid.
//  Drops stale in-flight responses after a redirect, so the first ivalid after a redirect always carries the target.
//  Sits between the controller/imem port and the decode stage.
// PARAMETERS
//  RESET_PC        64'h8000_0000  first fetch address after reset
//  MAX_OUTSTANDING 2              max requests in flight + instructions buffered (>=1)
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   reset, synchronous, active-high
//  jup             in   1   redirect strobe from controller (one cycle)
//  jup_addr        in   64  redirect target; bits [1:0] ignored, treated as 0
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  64  fetch address, bits [1:0] always 0
//  imem_resp_valid in   1   response valid; in-order, never back-pressured
//  imem_resp_data  in   32  instruction word
//  ivalid          out  1   inst/inst_pc valid toward decode and controller
//  id_ready        in   1   decode accepts instruction
//  inst            out  32  instruction
//  inst_pc         out  64  address of inst
// BEHAVIOUR
//  Reset: pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty, state RUN; imem_req_valid=0, ivalid=0, inst=0, inst_pc=0.
//  Reset mid-operation discards all state; responses to pre-reset requests are not tracked (memory is reset with us).
//  Request: imem_req_valid = !jup && (outstanding + fifo_count < MAX_OUTSTANDING).
//   imem_req_addr = pc; on req fire: pc <= pc+4, outstanding+1, push pc into in-flight PC queue.
//  Response: resp_valid pops in-flight PC queue, outstanding-1.
//   If drop_cnt != 0: discard, drop_cnt-1. Else push {pc, data} into output FIFO (depth MAX_OUTSTANDING).
//   Credit rule guarantees FIFO never overflows; resp_valid with outstanding==0 is a protocol error, ignored.
//  Output: ivalid = FIFO non-empty; inst/inst_pc from FIFO head; pop on ivalid && id_ready.
//   ivalid is held with stable inst/inst_pc while id_ready=0. Fetch-to-ivalid latency = memory latency + 1 cycle.
//  Redirect (jup=1):
//   no request issued that cycle; pc <= {jup_addr[63:2],2'b00}; FIFO flushed; ivalid forced 0 that cycle.
//   drop_cnt <= outstanding after this cycle's response (a response in the jup cycle is itself dropped/consumed).
//   In-flight PC queue keeps its entries; they are popped by stale responses.
//  FSM: RUN (drop_cnt==0) / FLUSH (drop_cnt!=0). RUN->FLUSH on jup with stale requests in flight;
//   FLUSH->RUN when last stale response is discarded; jup in FLUSH re-arms drop_cnt per rule above.
//   Requests to the new target may be issued during FLUSH (credits permitting); ivalid cannot assert in FLUSH.
//  Simultaneous req fire + resp: outstanding unchanged. Simultaneous push + pop: fifo_count unchanged.
//  Arithmetic: pc wraps modulo 2^64; counters are clog2(MAX_OUTSTANDING+1) bits and never exceed MAX_OUTSTANDING.
// TESTING
//  1 Reset, ready=1, 1-cycle memory, id_ready=1 -> reqs at 0x8000_0000,_0004,_0008; ivalid with inst_pc in same order.
//  2 id_ready=0 with MAX_OUTSTANDING=2 -> exactly 2 requests then imem_req_valid=0; ivalid/inst stable until id_ready=1.
//  3 Two requests in flight, jup with jup_addr=0x8000_0103 -> both stale responses dropped; first ivalid has inst_pc=0x8000_0100.
//  4 jup in same cycle as a response for 0x8000_0004 -> that response not delivered; drop_cnt = remaining outstanding (1).
//  5 Second jup to 0x9000_0000 during FLUSH -> all older responses dropped; first ivalid inst_pc=0x9000_0000.
//  6 rst asserted with FIFO full and requests in flight -> next cycle ivalid=0, imem_req_valid=0; restart at RESET_PC.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: signal bundle between the fetch stage and its neighbours.
//   Redirect      : jup, jup_addr                           (controller -> fetch)
//   Fetch request : imem_req_valid/ready, imem_req_addr      (fetch <-> imem)
//   Fetch response: imem_resp_valid, imem_resp_data          (imem -> fetch)
//   Instruction   : ivalid, id_ready, inst, inst_pc          (fetch <-> decode/controller)
// master = the fetch stage, slave = everything around it.
interface ifu_fetch_if;
  logic        jup;
  logic [63:0] jup_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        ivalid;
  logic        id_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  modport master (
    input  jup, jup_addr, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
    output imem_req_valid, imem_req_addr, ivalid, inst, inst_pc
  );

  modport slave (
    output jup, jup_addr, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
    input  imem_req_valid, imem_req_addr, ivalid, inst, inst_pc
  );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage answering the controller's redirect protocol.
// Issues word fetches to instruction memory, buffers the in-order responses and
// hands them to decode. After a redirect every response still in flight is
// discarded, so the first instruction presented afterwards is the target.
// Ports:
//   clk  in  clock, all state updates on posedge
//   rst  in  synchronous active-high reset
//   bus  ifu_fetch_if.master: redirect in, imem request/response, decode output
module ifu_fetch #(
  parameter logic [63:0] RESET_PC        = 64'h8000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master bus
);

  localparam int unsigned DEPTH = MAX_OUTSTANDING;
  localparam int unsigned CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] RESET_PC_ALIGNED = {RESET_PC[63:2], 2'b00};

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] data;
  } inst_entry_t;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] w_drop_nxt;

  logic [63:0]   r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] w_out_nxt;

  // In-flight PC queue: one entry per request still awaiting its response.
  logic [63:0]   r_pcq_mem [DEPTH];
  logic [PW-1:0] r_pcq_rd;
  logic [PW-1:0] r_pcq_wr;

  // Output FIFO of {pc, instruction} waiting for decode.
  inst_entry_t   r_fifo_mem [DEPTH];
  logic [PW-1:0] r_fifo_rd;
  logic [PW-1:0] r_fifo_wr;
  logic [CW-1:0] r_fifo_cnt;

  logic [CW:0]   w_in_use;
  logic          w_credit;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_resp;
  logic          w_dropping;
  logic          w_push;
  logic          w_ivalid;
  logic          w_pop;
  logic [63:0]   w_resp_pc;
  inst_entry_t   w_push_entry;
  inst_entry_t   w_head;

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits cover both requests in flight and instructions already buffered,
  // which is what keeps the output FIFO from ever overflowing.
  assign w_in_use    = {1'b0, r_outstanding} + {1'b0, r_fifo_cnt};
  assign w_credit    = w_in_use < (CW + 1)'(MAX_OUTSTANDING);
  assign w_req_valid = !rst && !bus.jup && w_credit;
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp      = bus.imem_resp_valid && (r_outstanding != '0);
  assign w_dropping  = (r_state == S_FLUSH);
  assign w_resp_pc   = r_pcq_mem[r_pcq_rd];

  // A response landing in the redirect cycle is stale as well.
  assign w_push       = w_resp && !w_dropping && !bus.jup;
  assign w_push_entry = {w_resp_pc, bus.imem_resp_data};

  assign w_head   = r_fifo_mem[r_fifo_rd];
  assign w_ivalid = !rst && !bus.jup && (r_fifo_cnt != '0);
  assign w_pop    = w_ivalid && bus.id_ready;

  // No request fires in a redirect cycle, so this is also the stale count.
  assign w_out_nxt = r_outstanding + CW'(w_req_fire) - CW'(w_resp);

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.ivalid         = w_ivalid;
  assign bus.inst           = w_head.data;
  assign bus.inst_pc        = w_head.pc;

  // FSM state and drop counter register.
  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      r_state    <= S_RUN;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_drop_cnt <= w_drop_nxt;
    end
  end

  // Next state: a redirect re-arms the drop count; each stale response retires one.
  always_comb begin : state_next
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop_cnt;
    if (bus.jup) begin
      w_drop_nxt  = w_out_nxt;
      w_state_nxt = (w_out_nxt != '0) ? S_FLUSH : S_RUN;
    end else if (w_resp && w_dropping) begin
      w_drop_nxt = r_drop_cnt - CW'(1);
      if (r_drop_cnt == CW'(1)) begin
        w_state_nxt = S_RUN;
      end
    end
  end

  // PC, outstanding count and in-flight PC queue.
  always_ff @(posedge clk) begin : fetch_reg
    if (rst) begin
      r_pc          <= RESET_PC_ALIGNED;
      r_outstanding <= '0;
      r_pcq_rd      <= '0;
      r_pcq_wr      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_pcq_mem[PW'(i)] <= '0;
      end
    end else begin
      r_outstanding <= w_out_nxt;
      if (bus.jup) begin
        r_pc <= {bus.jup_addr[63:2], 2'b00};
      end else if (w_req_fire) begin
        r_pc <= r_pc + 64'd4;
      end
      if (w_req_fire) begin
        r_pcq_mem[r_pcq_wr] <= r_pc;
        r_pcq_wr            <= ptr_inc(r_pcq_wr);
      end
      // Stale responses still pop their PC so the queue stays aligned.
      if (w_resp) begin
        r_pcq_rd <= ptr_inc(r_pcq_rd);
      end
    end
  end

  // Output FIFO; a redirect empties it in one cycle.
  always_ff @(posedge clk) begin : fifo_reg
    if (rst) begin
      r_fifo_rd  <= '0;
      r_fifo_wr  <= '0;
      r_fifo_cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_fifo_mem[PW'(i)] <= '0;
      end
    end else if (bus.jup) begin
      r_fifo_rd  <= r_fifo_wr;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fifo_mem[r_fifo_wr] <= w_push_entry;
        r_fifo_wr             <= ptr_inc(r_fifo_wr);
      end
      if (w_pop) begin
        r_fifo_rd <= ptr_inc(r_fifo_rd);
      end
      r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule
